// File: rtl/ifu.sv
// ============================================================================
//  Module   : ifu
//  Purpose  : Single-outstanding instruction fetch unit with ready/valid
//             memory handshake, held-instruction interface and sticky error.
//             Optional response watchdog enabled by macro IFU_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu #(
    parameter logic [31:0] RESET_PC       = 32'h8000_0000,
    parameter int          TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    input  logic        pc_we,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic        ar_valid,
    input  logic        ar_ready,
    output logic [31:0] ar_addr,
    input  logic        r_valid,
    output logic        r_ready,
    input  logic [31:0] r_data,
    input  logic [1:0]  r_resp,
    output logic        fetch_err
);

    localparam logic [31:0] C_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        err_q, err_d;

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_bad
        $error("ifu: TIMEOUT_CYCLES must be at least 1");
    end

`ifdef IFU_TIMEOUT_EN
    localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0] wd_q, wd_d;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        err_d   = err_q;
`ifdef IFU_TIMEOUT_EN
        wd_d    = wd_q;
`endif
        case (state_q)
            S_REQ: begin
                if (ar_ready) begin
                    state_d = S_WAIT;
`ifdef IFU_TIMEOUT_EN
                    wd_d    = '0;
`endif
                end
            end
            S_WAIT: begin
                if (r_valid) begin
                    if (r_resp == 2'b00) begin
                        inst_d  = r_data;
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
`ifdef IFU_TIMEOUT_EN
                // The cycle that reaches the limit is itself the last WAIT cycle.
                else if (wd_q == WD_LAST) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            S_HOLD: begin
                if (pc_we) begin
                    pc_d = pc_in;
                    if (pc_in[1:0] == 2'b00) begin
                        state_d = S_REQ;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_ERR;
                err_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            inst_q  <= C_NOP;
            err_q   <= 1'b0;
`ifdef IFU_TIMEOUT_EN
            wd_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            err_q   <= err_d;
`ifdef IFU_TIMEOUT_EN
            wd_q    <= wd_d;
`endif
        end
    end

    // Handshake outputs decode straight from state, so ar_valid and r_ready are exclusive.
    assign ar_valid   = (state_q == S_REQ);
    assign r_ready    = (state_q == S_WAIT);
    assign inst_valid = (state_q == S_HOLD);
    assign ar_addr    = pc_q;
    assign pc         = pc_q;
    assign inst       = inst_q;
    assign fetch_err  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_ifu.sv
// ============================================================================
//  Module   : tb_ifu
//  Purpose  : Randomized scoreboard bench for ifu (IFU_TIMEOUT_EN aware).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ifu;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam int          TMO      = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_in = '0;
    logic        pc_we = 1'b0;
    logic [31:0] pc, inst, ar_addr;
    logic        inst_valid, ar_valid, r_ready, fetch_err;
    logic        ar_ready = 1'b0;
    logic        r_valid = 1'b0;
    logic [31:0] r_data = '0;
    logic [1:0]  r_resp = '0;

    always #5 clk = ~clk;

    ifu #(.RESET_PC(RESET_PC), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .pc_we(pc_we), .pc(pc),
        .inst(inst), .inst_valid(inst_valid), .ar_valid(ar_valid),
        .ar_ready(ar_ready), .ar_addr(ar_addr), .r_valid(r_valid),
        .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
        .fetch_err(fetch_err)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Expected observable events: a new held instruction, or entry into the error state.
    typedef struct {
        bit          is_err;
        logic [31:0] pc;
        logic [31:0] inst;
    } ev_t;
    ev_t         exp_q[$];
    logic [31:0] m_inst;

    logic        prev_iv  = 1'b0;
    logic        prev_err = 1'b0;
    logic [31:0] held_pc, held_inst;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ar_valid && r_ready) begin
                checks++;
                failures++;
                $display("FAIL handshake_overlap actual=both_high required=exclusive");
            end
            if (inst_valid && !prev_iv) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_inst actual pc=%h inst=%h required=no_event", pc, inst);
                end else begin
                    ev_t ev;
                    ev = exp_q.pop_front();
                    chk("inst_event_kind", 32'(ev.is_err), 32'd0);
                    chk("inst_pc", pc, ev.pc);
                    chk("inst_word", inst, ev.inst);
                end
                held_pc   = pc;
                held_inst = inst;
            end else if (inst_valid && prev_iv) begin
                chk("hold_pc_stable", pc, held_pc);
                chk("hold_inst_stable", inst, held_inst);
            end
            if (fetch_err && !prev_err) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_err actual pc=%h required=no_event", pc);
                end else begin
                    ev_t ev;
                    ev = exp_q.pop_front();
                    chk("err_event_kind", 32'(ev.is_err), 32'd1);
                    chk("err_pc", pc, ev.pc);
                    chk("err_inst_kept", inst, ev.inst);
                    chk("err_iv_low", 32'(inst_valid), 32'd0);
                end
            end
            prev_iv  = inst_valid;
            prev_err = fetch_err;
        end
    end

    task automatic junk_we();
        if ($urandom_range(0, 3) == 0) begin
            pc_we = 1'b1;
            pc_in = $urandom;
        end else begin
            pc_we = 1'b0;
        end
    endtask

    // Called in REQ; leaves the bench one cycle after the response edge.
    task automatic do_fetch(input logic [31:0] a, input int stall, input int delay,
                            input logic [1:0] resp, input logic [31:0] data);
        ev_t ev;
        chk("req_valid", 32'(ar_valid), 32'd1);
        chk("req_addr", ar_addr, a);
        chk("req_iv_low", 32'(inst_valid), 32'd0);
        repeat (stall) begin
            ar_ready = 1'b0;
            junk_we();
            @(negedge clk);
        end
        pc_we = 1'b0;
        if (stall > 0) begin
            chk("stall_valid", 32'(ar_valid), 32'd1);
            chk("stall_addr", ar_addr, a);
        end
        ar_ready = 1'b1;
        @(negedge clk);
        ar_ready = 1'b0;
        chk("wait_rready", 32'(r_ready), 32'd1);
        repeat (delay) begin
            junk_we();
            @(negedge clk);
        end
        pc_we     = 1'b0;
        ev.is_err = (resp != 2'b00);
        ev.pc     = a;
        ev.inst   = (resp == 2'b00) ? data : m_inst;
        exp_q.push_back(ev);
        if (resp == 2'b00) m_inst = data;
        r_valid = 1'b1;
        r_data  = data;
        r_resp  = resp;
        @(negedge clk);
        r_valid = 1'b0;
        r_data  = $urandom;
        r_resp  = 2'($urandom);
    endtask

    // Called in HOLD; stray responses are offered, then the core redirects.
    task automatic hold_next(input logic [31:0] npc, input int dwell);
        ev_t ev;
        repeat (dwell) begin
            r_valid = 1'($urandom_range(0, 1));
            r_data  = $urandom;
            r_resp  = 2'b00;
            @(negedge clk);
        end
        r_valid = 1'b0;
        if (npc[1:0] != 2'b00) begin
            ev.is_err = 1'b1;
            ev.pc     = npc;
            ev.inst   = m_inst;
            exp_q.push_back(ev);
        end
        pc_we = 1'b1;
        pc_in = npc;
        @(negedge clk);
        pc_we = 1'b0;
        chk("post_we_iv_low", 32'(inst_valid), 32'd0);
        chk("post_we_pc", pc, npc);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        ar_ready = 1'b0;
        r_valid  = 1'b0;
        pc_we    = 1'b0;
        @(negedge clk);
        chk("rst_pc", pc, RESET_PC);
        chk("rst_inst", inst, 32'h0000_0013);
        chk("rst_iv", 32'(inst_valid), 32'd0);
        chk("rst_err", 32'(fetch_err), 32'd0);
        chk("rst_rready", 32'(r_ready), 32'd0);
        rst    = 1'b0;
        m_inst = 32'h0000_0013;
    endtask

    initial begin
        logic [31:0] a;
        m_inst = 32'h0000_0013;
        repeat (2) @(negedge clk);
        do_reset();

        do_fetch(RESET_PC, 0, 0, 2'b00, 32'h0010_0093);
        chk("first_iv", 32'(inst_valid), 32'd1);
        chk("first_inst", inst, 32'h0010_0093);
        chk("first_err", 32'(fetch_err), 32'd0);

        // Zero-wait redirect: instruction valid three cycles after the pulse.
        hold_next(32'h8000_0004, 2);
        do_fetch(32'h8000_0004, 0, 0, 2'b00, $urandom);
        chk("latency_iv", 32'(inst_valid), 32'd1);

        hold_next(32'h8000_0008, 1);
        do_fetch(32'h8000_0008, 5, 1, 2'b00, $urandom);

        for (int i = 0; i < 30; i++) begin
            a = RESET_PC + {18'd0, 12'($urandom_range(0, 4095)), 2'b00};
            hold_next(a, $urandom_range(0, 3));
            do_fetch(a, $urandom_range(0, 4), $urandom_range(0, 4), 2'b00, $urandom);
        end

        // Reset during WAIT, with a late response arriving afterwards.
        hold_next(32'h8000_0100, 0);
        ar_ready = 1'b1;
        @(negedge clk);
        ar_ready = 1'b0;
        chk("midrst_wait", 32'(r_ready), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        r_valid = 1'b1;
        r_resp  = 2'b00;
        r_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        r_valid = 1'b0;
        m_inst  = 32'h0000_0013;
        chk("late_resp_inst", inst, 32'h0000_0013);
        chk("late_resp_iv", 32'(inst_valid), 32'd0);
        chk("late_resp_addr", ar_addr, RESET_PC);
        do_fetch(RESET_PC, 2, 1, 2'b00, $urandom);

        // Misaligned redirect.
        hold_next(32'h8000_0002, 1);
        for (int i = 0; i < 6; i++) begin
            pc_we = 1'b1;
            pc_in = RESET_PC;
            @(negedge clk);
            chk("misalign_no_req", 32'(ar_valid), 32'd0);
            chk("misalign_err", 32'(fetch_err), 32'd1);
            chk("misalign_pc", pc, 32'h8000_0002);
        end
        pc_we = 1'b0;

        // Error response, then recovery through reset.
        do_reset();
        do_fetch(RESET_PC, 1, 2, 2'b10, 32'hBAD0_BAD0);
        for (int i = 0; i < 5; i++) begin
            pc_we = 1'b1;
            pc_in = 32'h8000_0010;
            @(negedge clk);
            chk("errresp_err", 32'(fetch_err), 32'd1);
            chk("errresp_iv", 32'(inst_valid), 32'd0);
            chk("errresp_no_req", 32'(ar_valid), 32'd0);
        end
        pc_we = 1'b0;
        do_reset();
        do_fetch(RESET_PC, 0, 0, 2'b00, 32'h0000_1111);
        chk("recover_iv", 32'(inst_valid), 32'd1);

        // Response never arrives.
        hold_next(32'h8000_0040, 0);
        ar_ready = 1'b1;
        @(negedge clk);
        ar_ready = 1'b0;
`ifdef IFU_TIMEOUT_EN
        begin
            ev_t ev;
            ev.is_err = 1'b1;
            ev.pc     = 32'h8000_0040;
            ev.inst   = m_inst;
            exp_q.push_back(ev);
        end
        repeat (TMO - 1) @(negedge clk);
        chk("tmo_not_yet", 32'(fetch_err), 32'd0);
        chk("tmo_still_wait", 32'(r_ready), 32'd1);
        @(negedge clk);
        chk("tmo_err", 32'(fetch_err), 32'd1);
        chk("tmo_rready_low", 32'(r_ready), 32'd0);
`else
        repeat (TMO + 44) @(negedge clk);
        chk("nowd_rready", 32'(r_ready), 32'd1);
        chk("nowd_err", 32'(fetch_err), 32'd0);
        chk("nowd_no_req", 32'(ar_valid), 32'd0);
`endif
        do_reset();
        do_fetch(RESET_PC, 1, 1, 2'b00, $urandom);

        @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "bench time limit reached");
    end

endmodule

`default_nettype wire

// File: doc/ifu.md
IFU -- requirements
Module: ifu

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000, is the first fetch address after reset.
REQ-002 Parameter TIMEOUT_CYCLES, default 256, sets the response watchdog limit (used only with IFU_TIMEOUT_EN).
REQ-003 clk  input  1  clock; all state changes occur on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 pc_in  input  32  next PC from the core datapath.
REQ-006 pc_we  input  1  core accepts the held instruction and supplies pc_in (one-cycle pulse).
REQ-007 pc  output  32  address of the instruction currently fetched or held.
REQ-008 inst  output  32  fetched instruction word, valid while inst_valid=1.
REQ-009 inst_valid  output  1  inst is valid and stable for the core.
REQ-010 ar_valid  output  1  read request valid to instruction memory.
REQ-011 ar_ready  input  1  memory accepts the request.
REQ-012 ar_addr  output  32  request address, always equal to pc.
REQ-013 r_valid  input  1  read response valid.
REQ-014 r_ready  output  1  IFU accepts the response.
REQ-015 r_data  input  32  response data.
REQ-016 r_resp  input  2  response status; 2'b00 means OKAY, any other value is an error.
REQ-017 fetch_err  output  1  sticky error flag.

Function
REQ-018 The IFU SHALL implement four states: REQ, WAIT, HOLD, ERR.
REQ-019 REQ: ar_valid=1. On ar_valid&&ar_ready the IFU SHALL go to WAIT on the next edge. ar_addr SHALL be stable while ar_valid=1.
REQ-020 WAIT: r_ready=1. On r_valid with r_resp=2'b00 the IFU SHALL latch r_data into inst and go to HOLD.
REQ-021 WAIT: on r_valid with r_resp!=2'b00 the IFU SHALL go to ERR and set fetch_err; inst SHALL be left unchanged.
REQ-022 HOLD: inst_valid=1. inst and pc SHALL remain stable until pc_we=1.
REQ-023 HOLD with pc_we=1 and pc_in[1:0]=2'b00: pc SHALL load pc_in, inst_valid SHALL drop on the same edge, and the state SHALL go to REQ. The new request SHALL issue in the following cycle.
REQ-024 HOLD with pc_we=1 and pc_in[1:0]!=2'b00 (misaligned): pc SHALL load pc_in, and the state SHALL go to ERR with fetch_err set.
REQ-025 pc_we in REQ, WAIT or ERR SHALL be ignored.
REQ-026 ERR: ar_valid=0, r_ready=0, inst_valid=0. ERR SHALL persist until rst.
REQ-027 Minimum latency from pc_we to inst_valid with zero-wait memory (ar_ready=1, r_valid in the cycle after acceptance) SHALL be 3 cycles.
REQ-028 ar_valid and r_ready SHALL never be asserted in the same cycle.
REQ-029 A response arriving outside WAIT SHALL be ignored.

Reset
REQ-030 While rst=1 at a clock edge: pc=RESET_PC, inst=32'h0000_0013 (nop), inst_valid=0, fetch_err=0, watchdog=0, state=REQ.
REQ-031 Reset asserted mid-transaction (WAIT or REQ) SHALL abandon the transaction. A late response SHALL be ignored under REQ-029.
REQ-032 The first ar_valid SHALL be asserted in the first cycle after rst deasserts.

Configuration
REQ-033 Macro IFU_TIMEOUT_EN defined: a counter SHALL clear on entry to WAIT and increment each WAIT cycle without r_valid. When it reaches TIMEOUT_CYCLES, the IFU SHALL go to ERR and set fetch_err.
REQ-034 Macro IFU_TIMEOUT_EN undefined: no counter SHALL exist, and WAIT SHALL last until r_valid.

Verification
REQ-035 Reset release, ar_ready=1, r_valid the next cycle with r_data=32'h0010_0093 and r_resp=0 -> ar_addr=32'h8000_0000, then inst=32'h0010_0093 with inst_valid=1 and fetch_err=0.
REQ-036 In HOLD, pulse pc_we with pc_in=32'h8000_0004 -> inst_valid=0 the next cycle, ar_addr=32'h8000_0004, and inst_valid=1 three cycles after the pulse.
REQ-037 Hold ar_ready=0 for 5 cycles -> ar_valid stays 1 with ar_addr constant, and no state advance.
REQ-038 Response with r_resp=2'b10 -> fetch_err=1 and inst_valid=0 permanently; pc_we is ignored; rst then clears fetch_err and refetches 32'h8000_0000.
REQ-039 pc_we with pc_in=32'h8000_0002 -> ERR, fetch_err=1, and no ar_valid issued.
REQ-040 With IFU_TIMEOUT_EN, no r_valid for 256 cycles -> fetch_err=1 at cycle 256. Without the macro, the IFU stays in WAIT with r_ready=1.
